// File: rtl/spi_eeprom_pkg.sv
// Shared opcodes and protocol state type for the SPI EEPROM responder.
// OP_READ is also the fetcher's EEPROM read command.
package spi_eeprom_pkg;

    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] OP_WREN  = 8'h06;
    localparam logic [7:0] OP_WRDI  = 8'h04;
    localparam logic [7:0] OP_RDSR  = 8'h05;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_ADDR    = 3'd2,
        ST_RD_DATA = 3'd3,
        ST_WR_DATA = 3'd4,
        ST_RDSR    = 3'd5,
        ST_IGNORE  = 3'd6
    } state_e;

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin, with rise/fall
// pulses taken from the last stage and a delayed copy of it.
module spi_pin_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              dly_q;
    logic              dly_d;

    // Shift the pin into the chain and keep a one-cycle delayed copy of the output.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
        dly_d  = sync_q[STAGES-1];
    end

    // Chain resets low; for cs_n this means a pin already low at reset release
    // produces no fall, so only a fresh cs_n fall starts a transaction.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= {STAGES{1'b0}};
            dly_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            dly_q  <= dly_d;
        end
    end

    assign q    = sync_q[STAGES-1];
    assign rise = sync_q[STAGES-1] & ~dly_q;
    assign fall = ~sync_q[STAGES-1] & dly_q;

endmodule

// File: rtl/spi_eeprom_responder.sv
// SPI mode-0 responder emulating a 25xx serial EEPROM over an internal byte
// array; all SPI pins are oversampled in the clk domain.
module spi_eeprom_responder
    import spi_eeprom_pkg::*;
#(
    parameter int MEM_AW      = 6,
    parameter int ADDR_BYTES  = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs_n,
    input  logic              sck,
    input  logic              copi,
    output logic              cipo,
    output logic              cipo_oe,
    input  logic              load_en,
    input  logic [MEM_AW-1:0] load_addr,
    input  logic [7:0]        load_data,
    output logic              busy,
    output logic              wel,
    output logic              cmd_err
);

    localparam int                DEPTH      = 2 ** MEM_AW;
    localparam int                ADDR_BITS  = ADDR_BYTES * 8;
    localparam logic [1:0]        ABYTE_LAST = 2'(ADDR_BYTES - 1);
    localparam logic [MEM_AW-1:0] ADDR_ONE   = {{(MEM_AW-1){1'b0}}, 1'b1};

    logic [7:0] mem_q [DEPTH];

    logic cs_s, cs_rise_s, cs_fall_s;
    logic sck_s, sck_rise_s, sck_fall_s;
    logic copi_s, copi_rise_s, copi_fall_s;
    logic unused_s;

    state_e                 state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [1:0]             abyte_q, abyte_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic [6:0]             rx_shift_q, rx_shift_d;
    logic [7:0]             tx_shift_q, tx_shift_d;
    logic                   op_write_q, op_write_d;
    logic                   cipo_q, cipo_d;
    logic                   cipo_oe_q, cipo_oe_d;
    logic                   busy_q, busy_d;
    logic                   wel_q, wel_d;
    logic                   cmd_err_q, cmd_err_d;

    logic [MEM_AW-1:0]      addr_lo_s;
    logic [7:0]             rx_byte_s, tx_byte_s;
    logic                   byte_done_s, spi_we_s;
    logic                   mem_we_s;
    logic [MEM_AW-1:0]      mem_waddr_s;
    logic [7:0]             mem_wdata_s;

    spi_pin_sync #(.STAGES(SYNC_STAGES)) u_cs_sync (
        .clk(clk), .rst_n(rst_n), .d(cs_n), .q(cs_s), .rise(cs_rise_s), .fall(cs_fall_s)
    );
    spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sck_sync (
        .clk(clk), .rst_n(rst_n), .d(sck), .q(sck_s), .rise(sck_rise_s), .fall(sck_fall_s)
    );
    spi_pin_sync #(.STAGES(SYNC_STAGES)) u_copi_sync (
        .clk(clk), .rst_n(rst_n), .d(copi), .q(copi_s), .rise(copi_rise_s), .fall(copi_fall_s)
    );

    assign unused_s    = cs_s ^ sck_s ^ copi_rise_s ^ copi_fall_s ^ addr_q[ADDR_BITS-1];
    assign addr_lo_s   = addr_q[MEM_AW-1:0];
    assign rx_byte_s   = {rx_shift_q, copi_s};
    assign byte_done_s = (bit_cnt_q == 3'd0);
    assign tx_byte_s   = (state_q == ST_RDSR) ? {6'b000000, wel_q, 1'b0} : mem_q[addr_lo_s];

    // Protocol FSM: cs_n edges first, then sck rise (sample), then sck fall (drive).
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        abyte_d    = abyte_q;
        addr_d     = addr_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        op_write_d = op_write_q;
        cipo_d     = cipo_q;
        cipo_oe_d  = cipo_oe_q;
        busy_d     = busy_q;
        wel_d      = wel_q;
        cmd_err_d  = cmd_err_q;
        spi_we_s   = 1'b0;
        if (cs_rise_s) begin
            state_d   = ST_IDLE;
            bit_cnt_d = 3'd7;
            abyte_d   = 2'd0;
            cipo_d    = 1'b0;
            cipo_oe_d = 1'b0;
            busy_d    = 1'b0;
            // A WRITE that reached its data phase always consumes the latch.
            wel_d     = (state_q == ST_WR_DATA) ? 1'b0 : wel_q;
        end else if (cs_fall_s) begin
            state_d   = ST_CMD;
            bit_cnt_d = 3'd7;
            abyte_d   = 2'd0;
            busy_d    = 1'b1;
        end else if (sck_rise_s) begin
            rx_shift_d = {rx_shift_q[5:0], copi_s};
            bit_cnt_d  = bit_cnt_q - 3'd1;
            case (state_q)
                ST_CMD: begin
                    if (byte_done_s) begin
                        case (rx_byte_s)
                            OP_READ:  begin state_d = ST_ADDR;   op_write_d = 1'b0; end
                            OP_WRITE: begin state_d = ST_ADDR;   op_write_d = 1'b1; end
                            OP_WREN:  begin state_d = ST_IGNORE; wel_d = 1'b1; end
                            OP_WRDI:  begin state_d = ST_IGNORE; wel_d = 1'b0; end
                            OP_RDSR:  begin state_d = ST_RDSR; end
                            default:  begin state_d = ST_IGNORE; cmd_err_d = 1'b1; end
                        endcase
                    end else begin
                        state_d = ST_CMD;
                    end
                end
                ST_ADDR: begin
                    addr_d = {addr_q[ADDR_BITS-2:0], copi_s};
                    if (byte_done_s && (abyte_q == ABYTE_LAST)) begin
                        state_d = op_write_q ? ST_WR_DATA : ST_RD_DATA;
                        abyte_d = 2'd0;
                    end else if (byte_done_s) begin
                        abyte_d = abyte_q + 2'd1;
                    end else begin
                        abyte_d = abyte_q;
                    end
                end
                ST_RD_DATA: begin
                    addr_d[MEM_AW-1:0] = byte_done_s ? (addr_lo_s + ADDR_ONE) : addr_lo_s;
                end
                ST_WR_DATA: begin
                    spi_we_s           = byte_done_s & wel_q;
                    addr_d[MEM_AW-1:0] = byte_done_s ? (addr_lo_s + ADDR_ONE) : addr_lo_s;
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end else begin
            if (sck_fall_s && ((state_q == ST_RD_DATA) || (state_q == ST_RDSR))) begin
                cipo_oe_d = 1'b1;
                if (bit_cnt_q == 3'd7) begin
                    cipo_d     = tx_byte_s[7];
                    tx_shift_d = {tx_byte_s[6:0], 1'b0};
                end else begin
                    cipo_d     = tx_shift_q[7];
                    tx_shift_d = {tx_shift_q[6:0], 1'b0};
                end
            end else begin
                cipo_d = cipo_q;
            end
        end
    end

    // Memory write port: host preload while idle, otherwise SPI data bytes.
    always_comb begin
        if (load_en && !busy_q) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = load_addr;
            mem_wdata_s = load_data;
        end else begin
            mem_we_s    = spi_we_s;
            mem_waddr_s = addr_lo_s;
            mem_wdata_s = rx_byte_s;
        end
    end

    // Byte array; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[mem_waddr_s] <= mem_wdata_s;
        end
    end

    // Protocol state and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 3'd7;
            abyte_q    <= 2'd0;
            addr_q     <= {ADDR_BITS{1'b0}};
            rx_shift_q <= 7'd0;
            tx_shift_q <= 8'd0;
            op_write_q <= 1'b0;
            cipo_q     <= 1'b0;
            cipo_oe_q  <= 1'b0;
            busy_q     <= 1'b0;
            wel_q      <= 1'b0;
            cmd_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            abyte_q    <= abyte_d;
            addr_q     <= addr_d;
            rx_shift_q <= rx_shift_d;
            tx_shift_q <= tx_shift_d;
            op_write_q <= op_write_d;
            cipo_q     <= cipo_d;
            cipo_oe_q  <= cipo_oe_d;
            busy_q     <= busy_d;
            wel_q      <= wel_d;
            cmd_err_q  <= cmd_err_d;
        end
    end

    assign cipo    = cipo_q;
    assign cipo_oe = cipo_oe_q;
    assign busy    = busy_q;
    assign wel     = wel_q;
    assign cmd_err = cmd_err_q;

endmodule
